// File: rtl/crc_16_rtu_rx_check.sv
// crc_16_rtu_rx_check: Modbus RTU receive-side CRC-16 frame checker
// Ports: clk; reset (async, active-high); byte_strb/byte_in incoming bytes (strobe edge-detected);
//   frame_end inter-frame silence pulse; busy while the bit-serial CRC engine shifts;
//   done one-cycle verdict pulse; crc_ok/crc_err/len_err/overrun held verdict flags;
//   byte_cnt/crc_rx/crc_calc held summary of the last frame.
module crc_16_rtu_rx_check #(
  parameter int MAX_BYTES = 256,
  parameter int MIN_BYTES = 4,
  localparam int CW = $clog2(MAX_BYTES + 2)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          byte_strb,
  input  logic [7:0]    byte_in,
  input  logic          frame_end,
  output logic          busy,
  output logic          done,
  output logic          crc_ok,
  output logic          crc_err,
  output logic          len_err,
  output logic          overrun,
  output logic [CW-1:0] byte_cnt,
  output logic [15:0]   crc_rx,
  output logic [15:0]   crc_calc
);
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
  state_t state, state_n;
  logic prev, pend_end, ovr, ok_r, err_r, len_r, ovr_r;
  logic strb_edge, chk, len_bad, match, v_ok, v_err;
  logic [7:0] h_old, h_new;
  logic [2:0] bit_cnt;
  logic [15:0] crc, crc_sh, rx_r, calc_r;
  logic [CW-1:0] cnt, cnt_inc, cnt_r;
  always_comb begin
    strb_edge = byte_strb & ~prev;
    chk = state == CHECK;
    cnt_inc = (cnt == CW'(MAX_BYTES + 1)) ? cnt : cnt + CW'(1);
    crc_sh = crc[0] ? (crc >> 1) ^ 16'hA001 : crc >> 1;
    len_bad = cnt < CW'(MIN_BYTES) || cnt > CW'(MAX_BYTES);
    match = crc == {h_new, h_old};
    v_ok = !len_bad && !ovr && match;
    v_err = !len_bad && !ovr && !match;
    state_n = state;
    case (state)
      // a pending end (byte and frame_end together) wins over any new byte
      IDLE: state_n = pend_end ? CHECK : strb_edge ? (cnt >= CW'(2) ? SHIFT : IDLE) : frame_end ? CHECK : IDLE;
      SHIFT: state_n = bit_cnt != 3'd7 ? SHIFT : (pend_end || frame_end) ? CHECK : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // verdict is shown live during CHECK and held from the registers afterwards
  always_comb begin
    done = chk;
    crc_ok = chk ? v_ok : ok_r;
    crc_err = chk ? v_err : err_r;
    len_err = chk ? len_bad : len_r;
    overrun = chk ? ovr : ovr_r;
    byte_cnt = chk ? cnt : cnt_r;
    crc_rx = chk ? {h_new, h_old} : rx_r;
    crc_calc = chk ? crc : calc_r;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= 1'b0;
      pend_end <= 1'b0;
      ovr <= 1'b0;
      busy <= 1'b0;
      bit_cnt <= 3'd0;
      h_old <= 8'h00;
      h_new <= 8'h00;
      crc <= 16'hFFFF;
      cnt <= '0;
      ok_r <= 1'b0;
      err_r <= 1'b0;
      len_r <= 1'b0;
      ovr_r <= 1'b0;
      cnt_r <= '0;
      rx_r <= 16'h0000;
      calc_r <= 16'h0000;
    end else begin
      prev <= byte_strb;
      case (state)
        IDLE: if (!pend_end && strb_edge) begin
          // the two newest bytes stay in the hold regs as the candidate CRC
          h_old <= h_new;
          h_new <= byte_in;
          cnt <= cnt_inc;
          pend_end <= frame_end;
          if (cnt >= CW'(2)) begin
            crc <= {crc[15:8], crc[7:0] ^ h_old};
            busy <= 1'b1;
            bit_cnt <= 3'd0;
          end
        end
        SHIFT: begin
          crc <= crc_sh;
          bit_cnt <= bit_cnt + 3'd1;
          if (strb_edge) ovr <= 1'b1;
          if (frame_end) pend_end <= 1'b1;
          if (bit_cnt == 3'd7) busy <= 1'b0;
        end
        default: begin
          ok_r <= v_ok;
          err_r <= v_err;
          len_r <= len_bad;
          ovr_r <= ovr;
          cnt_r <= cnt;
          rx_r <= {h_new, h_old};
          calc_r <= crc;
          crc <= 16'hFFFF;
          cnt <= '0;
          ovr <= 1'b0;
          pend_end <= 1'b0;
          h_old <= 8'h00;
          h_new <= 8'h00;
        end
      endcase
    end
  end
endmodule
